// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the iterative ALU arbiter: ALU mode
//               encoding, arbiter FSM states and the native ALU width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_data_w = 8;

    typedef enum logic [1:0] {
        ALU_SRA = 2'b00,
        ALU_SHL = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } alu_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } arb_state_e;

    // Modes 1x iterate on A (accumulate); modes 0x iterate on B (shift).
    function automatic logic mode_uses_a(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ALU.sv
`default_nettype none
// ============================================================================
// Module      : ALU
// Description : Single-step combinational 8-bit ALU (SRA B, SHL B, A+B, A-B).
// Revision    : 1.0 - initial release
// ============================================================================
module ALU
    import alu_pkg::*;
(
    input  logic [c_data_w-1:0] A,
    input  logic [c_data_w-1:0] B,
    input  logic [1:0]          mode,
    output logic [c_data_w-1:0] Y
);

    always_comb begin
        Y = '0;
        case (mode)
            ALU_SRA: Y = {B[c_data_w-1], B[c_data_w-1:1]};
            ALU_SHL: Y = {B[c_data_w-2:0], 1'b0};
            ALU_ADD: Y = A + B;
            ALU_SUB: Y = A - B;
            default: Y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_iter_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter_arb
// Description : Round-robin arbiter sharing one ALU between two requesters;
//               each command repeats its op cnt times with result feedback.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_arb
    import alu_pkg::*;
#(
    parameter int DATA_W = c_data_w,   // must match the ALU width
    parameter int CNT_W  = 3
)(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_vld,
    output logic              req0_rdy,
    input  logic [1:0]        req0_mode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CNT_W-1:0]  req0_cnt,

    input  logic              req1_vld,
    output logic              req1_rdy,
    input  logic [1:0]        req1_mode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CNT_W-1:0]  req1_cnt,

    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              busy
);

    arb_state_e        r_state;
    logic              r_prio;
    logic [DATA_W-1:0] r_wa;
    logic [DATA_W-1:0] r_wb;
    alu_mode_e         r_mode;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rsp_vld;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_id;

    logic              w_idle;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_acc;
    logic [1:0]        w_mode;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [CNT_W-1:0]  w_cnt;
    logic [DATA_W-1:0] w_y;

    assign w_idle = (r_state == IDLE);

    // Ready never looks at the requester's own valid, only at the rival's.
    assign req0_rdy = w_idle && (!r_prio || !req1_vld);
    assign req1_rdy = w_idle && ( r_prio || !req0_vld);

    assign w_acc0 = req0_vld && req0_rdy;
    assign w_acc1 = req1_vld && req1_rdy;
    assign w_acc  = w_acc0 || w_acc1;

    assign w_mode = w_acc1 ? req1_mode : req0_mode;
    assign w_a    = w_acc1 ? req1_a    : req0_a;
    assign w_b    = w_acc1 ? req1_b    : req0_b;
    assign w_cnt  = w_acc1 ? req1_cnt  : req0_cnt;

    ALU u_alu (
        .A    (r_wa),
        .B    (r_wb),
        .mode (r_mode),
        .Y    (w_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_prio     <= 1'b0;
            r_wa       <= '0;
            r_wb       <= '0;
            r_mode     <= ALU_SRA;
            r_cnt      <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_id   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_mode   <= alu_mode_e'(w_mode);
                        r_wa     <= w_a;
                        r_wb     <= w_b;
                        r_cnt    <= w_cnt;
                        r_rsp_id <= w_acc1;
                        // Zero iterations: the untouched working operand is the answer.
                        if (w_cnt == '0) begin
                            r_state    <= DONE;
                            r_rsp_vld  <= 1'b1;
                            r_rsp_data <= mode_uses_a(w_mode) ? w_a : w_b;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (mode_uses_a(r_mode)) begin
                        r_wa <= w_y;
                    end else begin
                        r_wb <= w_y;
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                    // The last step's ALU output is the final result.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state    <= DONE;
                        r_rsp_vld  <= 1'b1;
                        r_rsp_data <= w_y;
                    end
                end
                DONE: begin
                    if (rsp_rdy) begin
                        r_state   <= IDLE;
                        r_rsp_vld <= 1'b0;
                        r_prio    <= ~r_rsp_id;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rsp_vld  = r_rsp_vld;
    assign rsp_data = r_rsp_data;
    assign rsp_id   = r_rsp_id;
    assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_iter_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_iter_arb
// Description : Directed self-checking bench for alu_iter_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_iter_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_vld, req0_rdy, req1_vld, req1_rdy;
    logic [1:0] req0_mode, req1_mode;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_cnt, req1_cnt;
    logic       rsp_vld, rsp_rdy, rsp_id, busy;
    logic [7:0] rsp_data;

    int checks = 0;
    int errors = 0;
    int seen;

    always #5 clk = ~clk;

    alu_iter_arb #(.DATA_W(8), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_vld  (req0_vld),
        .req0_rdy  (req0_rdy),
        .req0_mode (req0_mode),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_cnt  (req0_cnt),
        .req1_vld  (req1_vld),
        .req1_rdy  (req1_rdy),
        .req1_mode (req1_mode),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_cnt  (req1_cnt),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit id, input logic v, input logic [1:0] m,
                         input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
        if (!id) begin
            req0_vld = v; req0_mode = m; req0_a = a; req0_b = b; req0_cnt = c;
        end else begin
            req1_vld = v; req1_mode = m; req1_a = a; req1_b = b; req1_cnt = c;
        end
    endtask

    // Single command on an idle block: accept, latency, data, id, release.
    task automatic run_cmd(input string tag, input bit id, input logic [1:0] m,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] c, input logic [7:0] exp);
        int lat;
        drive(id, 1'b1, m, a, b, c);
        #1;
        chk({tag, "_rdy"}, id ? req1_rdy : req0_rdy, 1);
        tick();
        drive(id, 1'b0, 2'b01, 8'hFF, 8'hFF, 3'd7);
        lat = 1;
        while (!rsp_vld && lat < 64) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"},  lat, int'(c) + 1);
        chk({tag, "_data"}, rsp_data, exp);
        chk({tag, "_id"},   rsp_id, id);
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        chk({tag, "_vld_clr"}, rsp_vld, 0);
        chk({tag, "_busy_clr"}, busy, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        rsp_rdy = 1'b0;
        drive(0, 1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
        drive(1, 1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
        repeat (3) tick();

        chk("rst_vld",  rsp_vld, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_id",   rsp_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy0", req0_rdy, 1);
        chk("rst_rdy1", req1_rdy, 1);
        rst_n = 1'b1;
        tick();

        run_cmd("add1",   0, 2'b10, 8'h95, 8'h6E, 3'd1, 8'h03);
        run_cmd("sra3",   1, 2'b00, 8'h00, 8'h80, 3'd3, 8'hF0);
        run_cmd("shl2",   0, 2'b01, 8'h00, 8'h6E, 3'd2, 8'hB8);
        run_cmd("sub7",   0, 2'b11, 8'h10, 8'h03, 3'd7, 8'hFB);
        run_cmd("add0",   0, 2'b10, 8'h5A, 8'h33, 3'd0, 8'h5A);
        run_cmd("sra0",   1, 2'b00, 8'h77, 8'hC4, 3'd0, 8'hC4);

        // Both requesters contend from reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        drive(0, 1'b1, 2'b10, 8'h00, 8'h01, 3'd1);
        drive(1, 1'b1, 2'b10, 8'h00, 8'h01, 3'd1);
        #1;
        chk("rr0_rdy0", req0_rdy, 1);
        chk("rr0_rdy1", req1_rdy, 0);
        tick();
        chk("rr0_run_busy", busy, 1);
        chk("rr0_run_rdy1", req1_rdy, 0);
        tick();
        chk("rr0_vld",  rsp_vld, 1);
        chk("rr0_data", rsp_data, 8'h01);
        chk("rr0_id",   rsp_id, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_vld",  rsp_vld, 1);
            chk("hold_data", rsp_data, 8'h01);
            chk("hold_id",   rsp_id, 0);
            chk("hold_rdy1", req1_rdy, 0);
        end
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        chk("rr1_rdy1", req1_rdy, 1);
        chk("rr1_rdy0", req0_rdy, 0);
        tick();
        tick();
        chk("rr1_vld", rsp_vld, 1);
        chk("rr1_id",  rsp_id, 1);
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        chk("rr2_rdy0", req0_rdy, 1);
        chk("rr2_rdy1", req1_rdy, 0);
        tick();
        drive(0, 1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
        drive(1, 1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
        tick();
        chk("rr2_vld", rsp_vld, 1);
        chk("rr2_id",  rsp_id, 0);
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;

        // Reset in the middle of a long command abandons it.
        drive(0, 1'b1, 2'b11, 8'h10, 8'h03, 3'd7);
        tick();
        drive(0, 1'b0, 2'b00, 8'h00, 8'h00, 3'd0);
        tick();
        tick();
        chk("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("mid_busy", busy, 0);
        chk("mid_vld",  rsp_vld, 0);
        rst_n = 1'b1;
        rsp_rdy = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_vld) seen++;
        end
        rsp_rdy = 1'b0;
        chk("mid_no_rsp", seen, 0);
        run_cmd("post_rst", 0, 2'b10, 8'h21, 8'h12, 3'd2, 8'h45);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/alu_iter_arb.md
Name: alu_iter_arb

Overview:
- Shares one combinational 8-bit ALU (module ALU: modes 00 = SRA of B, 01 = B<<1, 10 = A+B, 11 = A-B) between two requesters.
- Round-robin arbitration with a valid/ready handshake on each requester and on the single response channel.
- Each command repeats its ALU op cnt times, feeding the result back into the working operand. This gives multi-bit shifts, A+N·B and A−N·B from a single-step ALU.
- Sits between the command sources and the ALU.

Parameters:
- DATA_W, 8, operand/result width; must equal the ALU width (fixed 8).
- CNT_W, 3, iteration-count width; cnt range 0..2^CNT_W-1.

Ports:
- clk  in  1  clock, all flops posedge.
- rst_n  in  1  synchronous active-low reset.
- req0_vld  in  1  requester 0 command valid.
- req0_rdy  out  1  requester 0 command accepted this cycle when high with req0_vld.
- req0_mode  in  2  ALU mode.
- req0_a  in  DATA_W  operand A.
- req0_b  in  DATA_W  operand B.
- req0_cnt  in  CNT_W  iteration count.
- req1_vld, req1_rdy, req1_mode, req1_a, req1_b, req1_cnt: same as requester 0, for requester 1.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response consumer ready.
- rsp_data  out  DATA_W  final result.
- rsp_id  out  1  requester that issued the command.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: synchronous; rst_n low at a posedge forces the following.
  - state=IDLE.
  - rsp_vld=0, rsp_data=0, rsp_id=0, busy=0.
  - Working regs wa/wb/mode/cnt = 0.
  - Priority pointer = requester 0.
  - Reset mid-RUN or mid-DONE abandons the command; no response is ever issued for it.
- FSM states: IDLE, RUN, DONE.
- IDLE, ready logic (combinational, never depends on own vld):
  - req0_rdy = IDLE && (prio==0 || !req1_vld).
  - req1_rdy = IDLE && (prio==1 || !req0_vld).
- IDLE, accept: on a handshake (vld && rdy) the block latches mode/a/b/cnt into mode_r/wa/wb/cnt_r and latches rsp_id.
  - Next state is RUN if cnt>0, otherwise DONE.
  - Both requesters valid: the one selected by prio wins; the other sees rdy=0.
- RUN, each cycle:
  - ALU is driven with A=wa, B=wb, mode=mode_r.
  - At the edge: if mode_r[1]==1, wa<=Y; otherwise wb<=Y.
  - cnt_r decrements; when it reaches 0 the next state is DONE.
- DONE:
  - rsp_vld=1.
  - rsp_data = mode_r[1] ? wa : wb, registered and stable while rsp_vld && !rsp_rdy.
  - On rsp_rdy: next state IDLE, rsp_vld=0, prio <= ~rsp_id.
- Pipelining: no new command is accepted in RUN or DONE; the earliest next accept is the cycle after the response handshake.
- Latency: response valid cnt+1 cycles after the accept edge.
- cnt=0: no ALU step is performed. Result is A for modes 1x and B for modes 0x.
- Arithmetic:
  - All results wrap modulo 2^DATA_W; no carry or overflow flags.
  - SRA iterates with the sign bit replicated.
  - SHL iterates by shifting zeros in.
- Inputs are ignored outside an accept handshake. Changes on the other requester during RUN or DONE have no effect.

Decomposition:
- Package alu_pkg holds:
  - mode enum: ALU_SRA=2'b00, ALU_SHL=2'b01, ALU_ADD=2'b10, ALU_SUB=2'b11.
  - FSM state enum: IDLE, RUN, DONE.
  - DATA_W default constant.
- Sole sub-module: one instance of the existing ALU (ports A, B, mode, Y).
- Arbitration and FSM stay in alu_iter_arb.

Test Plan:
- req0: mode=10, A=0x95, B=0x6E, cnt=1 → rsp_data=0x03, rsp_id=0, rsp_vld 2 cycles after accept.
- req1: mode=00, B=0x80, cnt=3 → 0xF0.
- req0: mode=01, B=0x6E, cnt=2 → 0xB8.
- req0: mode=11, A=0x10, B=0x03, cnt=7 → 0xFB (wrap).
- req0: mode=10, A=0x5A, cnt=0 → 0x5A after 1 cycle.
- Both valid from reset, each with mode=10, A=0, B=1, cnt=1:
  - req0 served first.
  - rsp_rdy held low 3 cycles: rsp_data/rsp_id must stay stable.
  - Next, req1 is served (round-robin).
  - req0 is served after that.
- rst_n low during RUN (cnt=7):
  - next cycle busy=0, rsp_vld=0.
  - No response appears.
  - A new command is then accepted normally.
